// File: rtl/lcd_lh507x_capture.sv
// Capture of an LH507x-style monochrome LCD bus into pixel strobes with
// (x, y) coordinates, frame pulses, lock status and sticky error flags.
// Every panel pin is asynchronous to clk. Each pin passes through two
// synchronizer flops. The strobes that need edge detection get a third register.
module lcd_lh507x_capture #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 144,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_hsync,
  input  logic       lcd_vsync,
  input  logic       lcd_latch,
  input  logic       lcd_clk,
  input  logic [1:0] lcd_data,
  input  logic       err_clr,
  output logic       px_valid,
  output logic [7:0] px_x,
  output logic [7:0] px_y,
  output logic [1:0] px_data,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked,
  output logic       line_err,
  output logic       frame_err
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      X_END    = 8'(WIDTH);
  localparam logic [7:0]      Y_LAST   = 8'(HEIGHT - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {HUNT = 1'b0, CAPTURE = 1'b1} state_t;

  state_t state, state_n;

  // Edge-detected strobes {hsync, latch, clk}; levels {vsync, data[1:0]}.
  // The levels only need the two metastability flops. Data shares its stage with
  // the pixel clock, so the sample taken on a falling edge is the shade
  // present at the pin when that edge arrived.
  logic [2:0] edge_p0, edge_p1, edge_p2;
  logic [2:0] lvl_p0, lvl_p1;

  logic       pix_fall, latch_rise, hsync_rise, vsync_lvl;
  logic [1:0] sample;

  logic [7:0]    x, y, x_n, y_n, x_pix;
  logic          over, over_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pv_n, fs_n, fd_n, lset, fset;

  // Synchronizer chain: two flops against metastability, third for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_p0 <= '0;
      edge_p1 <= '0;
      edge_p2 <= '0;
      lvl_p0  <= '0;
      lvl_p1  <= '0;
    end else begin
      edge_p0 <= {lcd_hsync, lcd_latch, lcd_clk};
      edge_p1 <= edge_p0;
      edge_p2 <= edge_p1;
      lvl_p0  <= {lcd_vsync, lcd_data};
      lvl_p1  <= lvl_p0;
    end
  end

  assign pix_fall   = edge_p2[0] & ~edge_p1[0];
  assign latch_rise = edge_p1[1] & ~edge_p2[1];
  assign hsync_rise = edge_p1[2] & ~edge_p2[2];
  assign vsync_lvl  = lvl_p1[2];
  assign sample     = lvl_p1[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_n;
  end

  // Next state and coordinate bookkeeping; pixel handled before latch
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    x_pix   = x;
    over_n  = over;
    cnt_n   = cnt;
    pv_n    = 1'b0;
    fs_n    = 1'b0;
    fd_n    = 1'b0;
    lset    = 1'b0;
    fset    = 1'b0;
    case (state)
      HUNT: begin
        cnt_n = '0;
        if (latch_rise && vsync_lvl) begin
          state_n = CAPTURE;
          x_n     = '0;
          y_n     = '0;
          over_n  = 1'b0;
          fs_n    = 1'b1;
        end
      end
      CAPTURE: begin
        if (pix_fall) begin
          if (x < X_END) begin
            pv_n  = 1'b1;
            x_pix = x + 8'd1;
          end else begin
            lset = 1'b1;
          end
        end
        x_n = hsync_rise ? 8'd0 : x_pix;
        if (latch_rise) begin
          cnt_n = '0;
          x_n   = '0;
          if (x_pix != X_END) lset = 1'b1;
          // End of the last line of the frame, unless it was already ended
          if (y == Y_LAST && !over) fd_n = 1'b1;
          if (vsync_lvl) begin
            y_n    = '0;
            over_n = 1'b0;
            fs_n   = 1'b1;
            if (y != Y_LAST) fset = 1'b1;
          end else if (y == Y_LAST) begin
            // Extra lines past the frame: y holds, each one is an error
            if (over) fset = 1'b1;
            over_n = 1'b1;
          end else begin
            y_n = y + 8'd1;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = HUNT;
          cnt_n   = '0;
          fset    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Lock status decoded straight from the state
  always_comb begin
    locked = (state == CAPTURE);
  end

  // Coordinate, pulse and sticky-flag registers; a new error beats err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      over        <= 1'b0;
      cnt         <= '0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      x           <= x_n;
      y           <= y_n;
      over        <= over_n;
      cnt         <= cnt_n;
      px_valid    <= pv_n;
      frame_start <= fs_n;
      frame_done  <= fd_n;
      if (pv_n) begin
        px_x    <= x;
        px_y    <= y;
        px_data <= sample;
      end
      line_err  <= lset | (line_err & ~err_clr);
      frame_err <= fset | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_lcd_lh507x_capture.sv
// Bench for lcd_lh507x_capture: table of directed bus operations with
// expected flags, hand sequences for frame/timeout/reset corner cases, and
// a randomized run checked against an event-level reference model.
module tb_lcd_lh507x_capture;

  localparam int W  = 160;
  localparam int H  = 144;
  localparam int TO = 1000;

  localparam int OP_P = 0;  // pixel(s), arg = shade
  localparam int OP_L = 1;  // latch, arg = vsync
  localparam int OP_H = 2;  // hsync
  localparam int OP_C = 3;  // err_clr
  localparam int OP_X = 4;  // latch (no vsync) coinciding with err_clr
  localparam int OP_B = 5;  // hsync and latch together

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_hsync = 1'b0, lcd_vsync = 1'b0, lcd_latch = 1'b0, lcd_clk = 1'b0;
  logic [1:0] lcd_data = 2'd0;
  logic       err_clr = 1'b0;
  logic       px_valid, frame_start, frame_done, locked, line_err, frame_err;
  logic [7:0] px_x, px_y;
  logic [1:0] px_data;

  always #5 clk = ~clk;

  lcd_lh507x_capture #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_latch(lcd_latch),
    .lcd_clk(lcd_clk), .lcd_data(lcd_data), .err_clr(err_clr),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .frame_start(frame_start), .frame_done(frame_done), .locked(locked),
    .line_err(line_err), .frame_err(frame_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // ---------------- reference model (bus-event level) ----------------
  typedef struct { int x; int y; int d; } px_t;
  px_t exp_q[$];
  int  mx = 0, my = 0, mfs = 0, mfd = 0;
  bit  mlock = 0, mover = 0, mline = 0, mframe = 0;

  task automatic m_pixel(input int d);
    px_t p;
    if (!mlock) return;
    if (mx < W) begin
      p.x = mx; p.y = my; p.d = d;
      exp_q.push_back(p);
      mx++;
    end else mline = 1;
  endtask

  task automatic m_latch(input bit vs);
    if (!mlock) begin
      if (vs) begin mlock = 1; mx = 0; my = 0; mover = 0; mfs++; end
      return;
    end
    if (mx != W) mline = 1;
    mx = 0;
    if (my == H - 1 && !mover) mfd++;
    if (vs) begin
      if (my != H - 1) mframe = 1;
      my = 0; mover = 0; mfs++;
    end else if (my == H - 1) begin
      if (mover) mframe = 1;
      mover = 1;
    end else my++;
  endtask

  task automatic m_clr();
    mline = 0; mframe = 0;
  endtask

  // ---------------- output monitor ----------------
  int fs_cnt = 0, fd_cnt = 0, pv_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) fs_cnt++;
      if (frame_done)  fd_cnt++;
      if (px_valid) begin
        pv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL px_unexpected: got px_x=%0d px_y=%0d, required no pixel", px_x, px_y);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          chk($sformatf("px(y%0d,x%0d) y*1024+x*4+d", e.y, e.x),
              int'(px_y) * 1024 + int'(px_x) * 4 + int'(px_data),
              e.y * 1024 + e.x * 4 + e.d);
        end
      end
    end
  end

  // ---------------- bus drivers ----------------
  task automatic flush();
    repeat (4) @(negedge clk);
  endtask

  task automatic d_pixel(input int d);
    m_pixel(d);
    @(negedge clk); lcd_clk = 1'b1;
    @(negedge clk); lcd_clk = 1'b0; lcd_data = 2'(d);
  endtask

  task automatic d_latch(input bit vs);
    m_latch(vs);
    @(negedge clk); lcd_latch = 1'b1; lcd_vsync = vs;
    @(negedge clk); lcd_latch = 1'b0; lcd_vsync = 1'b0;
  endtask

  task automatic d_hsync();
    if (mlock) mx = 0;
    @(negedge clk); lcd_hsync = 1'b1;
    @(negedge clk); lcd_hsync = 1'b0;
  endtask

  task automatic d_clr();
    flush();
    m_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  // err_clr lands in the same cycle the latch edge is acted on
  task automatic d_latch_clr();
    flush();
    m_clr();
    m_latch(1'b0);
    @(negedge clk); lcd_latch = 1'b1;
    @(negedge clk); lcd_latch = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic d_hsync_latch();
    m_latch(1'b0);
    @(negedge clk); lcd_hsync = 1'b1; lcd_latch = 1'b1;
    @(negedge clk); lcd_hsync = 1'b0; lcd_latch = 1'b0;
  endtask

  task automatic d_pix_latch(input int d);
    m_pixel(d);
    m_latch(1'b0);
    @(negedge clk); lcd_clk = 1'b1;
    @(negedge clk); lcd_clk = 1'b0; lcd_data = 2'(d); lcd_latch = 1'b1;
    @(negedge clk); lcd_latch = 1'b0;
  endtask

  task automatic d_reset();
    flush();
    mlock = 0; mx = 0; my = 0; mover = 0; mline = 0; mframe = 0;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct { int op; int cnt; int arg; int le; int fe; int lk; } vec_t;
  vec_t tbl[20];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0, fd0, pv0, k;
    bit seen;

    tbl[0]  = '{OP_P,   5, 1, 0, 0, 0};  // pixels while hunting are ignored
    tbl[1]  = '{OP_L,   1, 0, 0, 0, 0};  // latch without vsync: no lock
    tbl[2]  = '{OP_L,   1, 1, 0, 0, 1};  // vsync latch: lock
    tbl[3]  = '{OP_P, 159, 2, 0, 0, 1};
    tbl[4]  = '{OP_L,   1, 0, 1, 0, 1};  // short line
    tbl[5]  = '{OP_C,   1, 0, 0, 0, 1};
    tbl[6]  = '{OP_P, 160, 3, 0, 0, 1};  // next line from x=0
    tbl[7]  = '{OP_P,   1, 1, 1, 0, 1};  // 161st pixel dropped
    tbl[8]  = '{OP_L,   1, 0, 1, 0, 1};
    tbl[9]  = '{OP_C,   1, 0, 0, 0, 1};
    tbl[10] = '{OP_P,   3, 0, 0, 0, 1};
    tbl[11] = '{OP_H,   1, 0, 0, 0, 1};  // hsync rewinds x
    tbl[12] = '{OP_P, 160, 1, 0, 0, 1};
    tbl[13] = '{OP_L,   1, 0, 0, 0, 1};  // full line after hsync: clean
    tbl[14] = '{OP_P,  10, 2, 0, 0, 1};
    tbl[15] = '{OP_X,   1, 0, 1, 0, 1};  // error set beats err_clr
    tbl[16] = '{OP_B,   1, 0, 1, 0, 1};  // hsync+latch: latch rules
    tbl[17] = '{OP_C,   1, 0, 0, 0, 1};
    tbl[18] = '{OP_L,   1, 1, 1, 1, 1};  // vsync mid-frame (y=5)
    tbl[19] = '{OP_C,   1, 0, 0, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_px_valid", int'(px_valid), 0);
    chk("rst_px_x", int'(px_x), 0);
    chk("rst_px_y", int'(px_y), 0);
    chk("rst_px_data", int'(px_data), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_line_err", int'(line_err), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    flush();

    // Directed table
    for (int r = 0; r < 20; r++) begin
      for (int n = 0; n < tbl[r].cnt; n++) begin
        case (tbl[r].op)
          OP_P: d_pixel(tbl[r].arg);
          OP_L: d_latch(tbl[r].arg[0]);
          OP_H: d_hsync();
          OP_C: d_clr();
          OP_X: d_latch_clr();
          default: d_hsync_latch();
        endcase
      end
      flush();
      chk($sformatf("row%0d_line_err", r), int'(line_err), tbl[r].le);
      chk($sformatf("row%0d_frame_err", r), int'(frame_err), tbl[r].fe);
      chk($sformatf("row%0d_locked", r), int'(locked), tbl[r].lk);
    end

    // Full frame, data = x mod 4
    d_latch(1'b1);
    d_clr();
    flush();
    fd0 = fd_cnt; pv0 = pv_cnt;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) d_pixel(xx % 4);
      d_latch(1'b0);
    end
    flush();
    chk("frame_px_count", pv_cnt - pv0, 23040);
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("frame_line_err", int'(line_err), 0);
    chk("frame_frame_err", int'(frame_err), 0);
    fs0 = fs_cnt;
    d_latch(1'b1);
    flush();
    chk("frame_next_start", fs_cnt - fs0, 1);
    chk("frame_next_frame_err", int'(frame_err), 0);

    // vsync at the latch of line 100
    d_clr();
    for (int yy = 0; yy < 100; yy++) d_latch(1'b0);
    flush();
    fs0 = fs_cnt;
    d_latch(1'b1);
    flush();
    chk("l100_frame_err", int'(frame_err), 1);
    chk("l100_frame_start", fs_cnt - fs0, 1);
    d_pixel(2);
    flush();
    chk("l100_next_px_y", int'(px_y), 0);
    chk("l100_next_px_x", int'(px_x), 0);

    // Last pixel coincident with latch
    d_latch(1'b1);
    d_clr();
    for (int xx = 0; xx < W - 1; xx++) d_pixel(xx % 4);
    d_pix_latch(3);
    flush();
    chk("coinc_px_x", int'(px_x), 159);
    chk("coinc_px_y", int'(px_y), 0);
    chk("coinc_line_err", int'(line_err), 0);
    d_pixel(1);
    flush();
    chk("coinc_next_px_y", int'(px_y), 1);
    chk("coinc_next_px_x", int'(px_x), 0);

    // Randomized bus traffic against the model
    begin
      int since = 0;
      for (int i = 0; i < 1500; i++) begin
        int c;
        c = int'($urandom_range(0, 99));
        if (since > 100) c = 85;
        if (c < 80) begin
          d_pixel(int'($urandom_range(0, 3)));
          since++;
        end else if (c < 88) begin
          d_latch($urandom_range(0, 9) == 0);
          since = 0;
        end else if (c < 93) begin
          d_hsync();
          since++;
        end else if (c < 96) begin
          d_clr();
          since++;
        end else begin
          d_pix_latch(int'($urandom_range(0, 3)));
          since = 0;
        end
      end
      flush();
      chk("rand_line_err", int'(line_err), int'(mline));
      chk("rand_frame_err", int'(frame_err), int'(mframe));
      chk("rand_locked", int'(locked), int'(mlock));
      chk("rand_frame_starts", fs_cnt, mfs);
      chk("rand_frame_dones", fd_cnt, mfd);
      chk("rand_px_pending", exp_q.size(), 0);
    end

    // Stopped latch: timeout
    d_reset();
    d_latch(1'b1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1;
    end
    chk("to_frame_start_seen", int'(seen), 1);
    k = 0;
    while (locked && k < 1100) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, TO);
    chk("to_locked", int'(locked), 0);
    chk("to_frame_err", int'(frame_err), 1);

    // Reset mid-line, resync only on vsync latch
    d_reset();
    d_latch(1'b1);
    for (int xx = 0; xx < 20; xx++) d_pixel(1);
    d_reset();
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_frame_err", int'(frame_err), 0);
    for (int xx = 0; xx < 5; xx++) d_pixel(2);
    flush();
    chk("mrst_hunt_locked", int'(locked), 0);
    d_latch(1'b0);
    flush();
    chk("mrst_novs_locked", int'(locked), 0);
    d_latch(1'b1);
    flush();
    chk("mrst_vs_locked", int'(locked), 1);
    d_pixel(3);
    flush();
    chk("mrst_px_x", int'(px_x), 0);
    chk("mrst_px_y", int'(px_y), 0);
    chk("mrst_px_data", int'(px_data), 3);
    chk("end_px_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_lh507x_capture.md
LCD_LH507X_CAPTURE -- requirements
Module: lcd_lh507x_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 160, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 144, lines per frame.
REQ-003 SHALL have parameter TIMEOUT, default 65535, clk cycles without a latch edge before loss of sync.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port lcd_hsync  in  1  asynchronous line-start strobe from the panel bus.
REQ-007 SHALL have port lcd_vsync  in  1  asynchronous frame marker.
REQ-008 SHALL have port lcd_latch  in  1  asynchronous line-latch strobe.
REQ-009 SHALL have port lcd_clk  in  1  asynchronous pixel clock; data valid at its falling edge.
REQ-010 SHALL have port lcd_data  in  2  asynchronous pixel shade.
REQ-011 SHALL have port err_clr  in  1  clears sticky error flags.
REQ-012 SHALL have port px_valid  out  1  one-cycle strobe: px_x/px_y/px_data valid.
REQ-013 SHALL have ports px_x  out  8  and px_y  out  8  pixel coordinates.
REQ-014 SHALL have port px_data  out  2  captured shade.
REQ-015 SHALL have ports frame_start  out  1  and frame_done  out  1  one-cycle pulses.
REQ-016 SHALL have port locked  out  1  high while in CAPTURE.
REQ-017 SHALL have ports line_err  out  1  and frame_err  out  1  sticky error flags.

Function
REQ-018 SHALL pass every lcd_* input through a 2-flop synchronizer, then a third register for edge detection; pin-to-event latency SHALL be exactly 3 clk cycles.
REQ-019 SHALL capture lcd_data on the same synchronizer stage as lcd_clk, keeping data/clock skew at zero cycles.
REQ-020 SHALL implement states HUNT and CAPTURE; HUNT is the reset state.
REQ-021 In HUNT, SHALL ignore pixels; on a latch rising edge with synced vsync high, SHALL enter CAPTURE, set y=0 and x=0, and pulse frame_start.
REQ-022 In CAPTURE, on each lcd_clk falling edge with x<WIDTH, SHALL pulse px_valid one cycle later with px_x=x, px_y=y, px_data=sample, then increment x.
REQ-023 SHALL drop a falling edge received with x>=WIDTH and set line_err; x SHALL saturate at WIDTH.
REQ-024 SHALL set x=0 on an hsync rising edge; pixel count is unaffected otherwise.
REQ-025 On a latch rising edge in CAPTURE, SHALL set line_err if x!=WIDTH, then set x=0.
REQ-026 On that latch edge, with vsync high, SHALL start a new frame: set y=0, pulse frame_start, and set frame_err if y!=HEIGHT-1.
REQ-027 On that latch edge, with vsync low, SHALL increment y; when y was HEIGHT-1 it SHALL pulse frame_done and hold y at HEIGHT-1, setting frame_err on each further latch until vsync.
REQ-028 SHALL pulse frame_done on the latch ending line HEIGHT-1 (y==HEIGHT-1 before the edge), independent of vsync.
REQ-029 When a pixel edge and a latch edge occur in the same cycle, SHALL process the pixel first, with the old x/y, then the latch.
REQ-030 When hsync and latch edges coincide, SHALL apply the latch rules; x ends at 0.
REQ-031 SHALL count clk cycles since the last latch edge in CAPTURE; on reaching TIMEOUT it SHALL return to HUNT, drop locked, and set frame_err.
REQ-032 SHALL clear line_err and frame_err when err_clr is high; a set condition in the same cycle SHALL win.
REQ-033 SHALL hold locked high exactly while the state is CAPTURE.

Reset
REQ-034 While reset is high, SHALL force state=HUNT, x=y=0, timeout counter=0, synchronizer flops=0, and all outputs 0.
REQ-035 SHALL discard a reset asserted mid-line and resynchronize only on the next vsync-qualified latch edge.

Verification
REQ-036 SHALL verify a full frame: vsync+latch, then 144 lines of 160 pixels with data=x mod 4 -> 23040 px_valid pulses, px_data correct, one frame_done, errors 0.
REQ-037 SHALL verify a short line of 159 pixels then latch -> line_err=1; the next line restarts at px_x=0; err_clr -> line_err=0.
REQ-038 SHALL verify a 161st pixel edge -> no px_valid for it and line_err=1.
REQ-039 SHALL verify vsync at the latch of line 100 -> frame_err=1, frame_start pulse, next px_y=0.
REQ-040 SHALL verify a stopped lcd_latch with TIMEOUT=1000 -> locked falls 1000 cycles after the last latch edge and frame_err=1.
REQ-041 SHALL verify a pixel edge and latch edge coincident on the last pixel -> px_valid with px_x=159 and old px_y, then line advance, no line_err.
